univ_register: RTL

//   Parametrised universal register: clear, parallel load, increment/decrement
//   and one-bit shifts (logical, arithmetic or rotate) on a WIDTH-bit value.

---
 rtl/univ_register.sv | 81 ++++++++
 1 files changed

// File: rtl/univ_register.sv
// Universal WIDTH-bit register: clear, load, inc/dec (wrap or saturate) and
// one-bit logical/arithmetic/rotate shifts, with registered carry and live zero flag.
module univ_register #(
  parameter int               WIDTH   = 8,
  parameter int               SAT     = 0,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cl,
  input  logic             ld,
  input  logic [WIDTH-1:0] in,
  input  logic             inc,
  input  logic             dec,
  input  logic             sr,
  input  logic             ir,
  input  logic             sl,
  input  logic             il,
  input  logic             rot,
  input  logic             asr,
  output logic [WIDTH-1:0] out,
  output logic             carry,
  output logic             zero
);

  logic [WIDTH-1:0] r_out;
  logic             r_carry;

  logic [WIDTH:0]   w_sum;
  logic [WIDTH:0]   w_diff;
  logic             w_sr_msb;
  logic             w_sl_lsb;
  logic [WIDTH-1:0] w_next;
  logic             w_next_c;

  // Carry and borrow come from the extra bit of a WIDTH+1 wide operation.
  assign w_sum    = {1'b0, r_out} + {{WIDTH{1'b0}}, 1'b1};
  assign w_diff   = {1'b0, r_out} - {{WIDTH{1'b0}}, 1'b1};

  assign w_sr_msb = rot ? r_out[0] : (asr ? r_out[WIDTH-1] : ir);
  assign w_sl_lsb = rot ? r_out[WIDTH-1] : il;

  always_comb begin
    w_next   = r_out;
    w_next_c = r_carry;
    if (cl) begin
      w_next   = '0;
      w_next_c = 1'b0;
    end else if (ld) begin
      w_next   = in;
      w_next_c = 1'b0;
    end else if (inc) begin
      w_next_c = w_sum[WIDTH];
      w_next   = (w_sum[WIDTH] && (SAT != 0)) ? r_out : w_sum[WIDTH-1:0];
    end else if (dec) begin
      w_next_c = w_diff[WIDTH];
      w_next   = (w_diff[WIDTH] && (SAT != 0)) ? r_out : w_diff[WIDTH-1:0];
    end else if (sr) begin
      w_next   = {w_sr_msb, r_out[WIDTH-1:1]};
      w_next_c = r_out[0];
    end else if (sl) begin
      w_next   = {r_out[WIDTH-2:0], w_sl_lsb};
      w_next_c = r_out[WIDTH-1];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_out   <= RST_VAL;
      r_carry <= 1'b0;
    end else begin
      r_out   <= w_next;
      r_carry <= w_next_c;
    end
  end

  assign out   = r_out;
  assign carry = r_carry;
  assign zero  = (r_out == '0);

endmodule
